ex_stage: RTL

- Execute stage of the 5-stage MIPS pipeline. Consumes the ID/EX register outputs and computes the ALU result, branch target, zero flag and destination register.
- Its outputs are registered as the EX/MEM pipeline register, with stall and flush control, and feed the MEM stage directly.

---
 rtl/ex_stage.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU control decode, ALU, branch-target adder and
// destination select, all feeding the EX/MEM pipeline register (stall/flush aware).
module ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic [1:0]    wb_ctl,
  input  logic [2:0]    m_ctl,
  input  logic          regdst,
  input  logic          alusrc,
  input  logic [1:0]    aluop,
  input  logic [DW-1:0] npc,
  input  logic [DW-1:0] rdata1,
  input  logic [DW-1:0] rdata2,
  input  logic [DW-1:0] s_extend,
  input  logic [RW-1:0] instr_2016,
  input  logic [RW-1:0] instr_1511,
  output logic [1:0]    wb_ctlout,
  output logic          branch,
  output logic          memread,
  output logic          memwrite,
  output logic [DW-1:0] add_result,
  output logic          zero,
  output logic [DW-1:0] alu_result,
  output logic [DW-1:0] rdata2out,
  output logic [RW-1:0] dest_reg,
  output logic          illegal_op
);

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100
  } alu_ctl_e;

  typedef struct packed {
    logic [1:0]    wb;
    logic          branch;
    logic          memread;
    logic          memwrite;
    logic          illegal;
    logic [DW-1:0] add_result;
    logic          zero;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] rdata2;
    logic [RW-1:0] dest;
  } exmem_t;

  alu_ctl_e      alu_ctl;
  logic          illegal;
  logic [5:0]    funct;
  logic [DW-1:0] op_b;
  logic [DW-1:0] alu_raw;
  logic [DW-1:0] alu_out;
  exmem_t        nxt;
  exmem_t        q;

  assign funct = s_extend[5:0];
  assign op_b  = alusrc ? s_extend : rdata2;

  // ALU control decode; unsupported encodings raise illegal and force ADD as a don't-care
  always_comb begin
    alu_ctl = ALU_ADD;
    illegal = 1'b0;
    case (aluop)
      2'b00: alu_ctl = ALU_ADD;
      2'b01: alu_ctl = ALU_SUB;
      2'b10: begin
        case (funct)
          6'b100000: alu_ctl = ALU_ADD;
          6'b100010: alu_ctl = ALU_SUB;
          6'b100100: alu_ctl = ALU_AND;
          6'b100101: alu_ctl = ALU_OR;
          6'b101010: alu_ctl = ALU_SLT;
          6'b100111: alu_ctl = ALU_NOR;
          default:   illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    alu_raw = '0;
    case (alu_ctl)
      ALU_AND: alu_raw = rdata1 & op_b;
      ALU_OR:  alu_raw = rdata1 | op_b;
      ALU_ADD: alu_raw = rdata1 + op_b;
      ALU_SUB: alu_raw = rdata1 - op_b;
      ALU_SLT: alu_raw = {{(DW-1){1'b0}}, ($signed(rdata1) < $signed(op_b))};
      ALU_NOR: alu_raw = ~(rdata1 | op_b);
      default: alu_raw = '0;
    endcase
  end

  assign alu_out = illegal ? '0 : alu_raw;

  always_comb begin
    nxt            = '0;
    nxt.wb         = wb_ctl;
    nxt.branch     = m_ctl[2];
    nxt.memread    = m_ctl[1];
    nxt.memwrite   = m_ctl[0];
    nxt.illegal    = illegal;
    nxt.add_result = npc + {s_extend[DW-3:0], 2'b00};
    nxt.zero       = (alu_out == '0);
    nxt.alu_result = alu_out;
    nxt.rdata2     = rdata2;
    nxt.dest       = regdst ? instr_1511 : instr_2016;
  end

  // Flush beats stall: the bubble clears only the control bits, data still loads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (flush) begin
      q          <= nxt;
      q.wb       <= 2'b00;
      q.branch   <= 1'b0;
      q.memread  <= 1'b0;
      q.memwrite <= 1'b0;
      q.illegal  <= 1'b0;
    end else if (!stall) begin
      q <= nxt;
    end
  end

  assign wb_ctlout  = q.wb;
  assign branch     = q.branch;
  assign memread    = q.memread;
  assign memwrite   = q.memwrite;
  assign add_result = q.add_result;
  assign zero       = q.zero;
  assign alu_result = q.alu_result;
  assign rdata2out  = q.rdata2;
  assign dest_reg   = q.dest;
  assign illegal_op = q.illegal;

endmodule
